// File: rtl/round_cand_sel_pipe.sv
// round_cand_sel_pipe
//
// Registered rounding-candidate selector for the pipelined adder.
// One of N candidates, each packed as {ovf_rnd, mant}, is picked by in_sel.
// The result is registered behind a valid/ready handshake. A 2-entry skid
// buffer lets the rounding stage stall without dropping data.
//
// The ovf_rnd flag always comes from the same candidate as the mantissa.
// Out-of-range selects fall back to candidate 0 and are flagged.
// A saturating counter tracks delivered words that carry ovf_rnd=1.
//
// Optional feature (macro RND_OVF_NORM_EN):
//   When the selected ovf_rnd=1, the mantissa is normalised before it is
//   registered, giving {1'b1, mant[MW-1:1]}. out_ovf is still reported.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream candidates/select valid
//   in_ready     stage can accept (= !skid valid)
//   in_cand      N packed candidates, k at [k*(MW+1) +: MW+1]
//   in_sel       candidate index
//   out_valid    output word valid
//   out_ready    downstream accepts
//   out_mant     selected (optionally normalised) mantissa
//   out_ovf      selected candidate's ovf_rnd bit
//   out_sel_err  word came from an out-of-range select
//   cnt_clr      synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt      saturating count of delivered words with out_ovf=1
module round_cand_sel_pipe #(
    parameter  int N     = 4,
    parameter  int MW    = 24,
    parameter  int CNT_W = 16,
    localparam int SW    = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*(MW+1)-1:0] in_cand,
    input  logic [SW-1:0]       in_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MW-1:0]       out_mant,
    output logic                out_ovf,
    output logic                out_sel_err,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    ovf_cnt
);

    localparam int CW = MW + 1;
    localparam int DW = MW + 2;

    logic [CW-1:0]    w_selCand;
    logic             w_selErr;
    logic [MW-1:0]    w_rawMant;
    logic [MW-1:0]    w_selMant;
    logic [DW-1:0]    w_inWord;
    logic             w_inXfer;
    logic             w_outXfer;
    logic             w_mainFree;

    logic             r_mainValid;
    logic [DW-1:0]    r_mainData;
    logic             r_skidValid;
    logic [DW-1:0]    r_skidData;
    logic [CNT_W-1:0] r_ovfCnt;

    // Walk all legal indices instead of indexing with in_sel, so a select
    // beyond N-1 (non power-of-two N) never reads past the bus and instead
    // falls back to candidate 0 with the error flag raised.
    always_comb begin
        w_selCand = in_cand[CW-1:0];
        w_selErr  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(in_sel) == k) begin
                w_selCand = in_cand[k*CW +: CW];
                w_selErr  = 1'b0;
            end
        end
    end

    assign w_rawMant = w_selCand[MW-1:0];

`ifdef RND_OVF_NORM_EN
    // A rounding overflow carried into bit MW, so shift it back in as the
    // new leading one; the exponent stage still sees out_ovf=1.
    assign w_selMant = w_selCand[MW] ? {1'b1, w_rawMant[MW-1:1]} : w_rawMant;
`else
    assign w_selMant = w_rawMant;
`endif

    // Stored word layout: {sel_err, ovf, mant}.
    assign w_inWord   = {w_selErr, w_selCand[MW], w_selMant};
    assign in_ready   = !r_skidValid;
    assign w_inXfer   = in_valid && !r_skidValid;
    assign w_outXfer  = r_mainValid && out_ready;
    // Main can take a new word when it is empty or is being drained now.
    assign w_mainFree = !r_mainValid || out_ready;

    // Skid data moves up first so ordering is preserved. in_ready is low
    // whenever skid holds a word, so a refill from skid never competes
    // with a new input in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
        end else if (w_mainFree) begin
            if (r_skidValid) begin
                r_mainValid <= 1'b1;
                r_mainData  <= r_skidData;
                r_skidValid <= 1'b0;
            end else if (w_inXfer) begin
                r_mainValid <= 1'b1;
                r_mainData  <= w_inWord;
            end else begin
                r_mainValid <= 1'b0;
            end
        end else if (w_inXfer) begin
            r_skidValid <= 1'b1;
            r_skidData  <= w_inWord;
        end
    end

    // Clear beats increment; the count sticks at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfCnt <= '0;
        end else if (cnt_clr) begin
            r_ovfCnt <= '0;
        end else if (w_outXfer && r_mainData[MW] && (r_ovfCnt != '1)) begin
            r_ovfCnt <= r_ovfCnt + 1'b1;
        end
    end

    assign out_valid   = r_mainValid;
    assign out_mant    = r_mainData[MW-1:0];
    assign out_ovf     = r_mainData[MW];
    assign out_sel_err = r_mainData[MW+1];
    assign ovf_cnt     = r_ovfCnt;

endmodule

// File: tb/tb_round_cand_sel_pipe.sv
// tb_round_cand_sel_pipe
//
// Directed bench for round_cand_sel_pipe. Two instances share clock/reset:
//   dutA: N=4, MW=24, CNT_W=16
//   dutB: N=3, MW=24, CNT_W=4 (out-of-range select, counter saturation)
// Expected words are computed from the driven candidates and queued when an
// input transfer happens, then popped and compared on each output transfer.
// Honours RND_OVF_NORM_EN the same way as the design.
module tb_round_cand_sel_pipe;

    typedef struct packed {
        logic [23:0] mant;
        logic        ovf;
        logic        err;
    } word_t;

    logic        clk;
    logic        rst_n;

    logic        inValidA, inReadyA, outValidA, outReadyA;
    logic [99:0] inCandA;
    logic [1:0]  inSelA;
    logic [23:0] outMantA;
    logic        outOvfA, outSelErrA, cntClrA;
    logic [15:0] ovfCntA;

    logic        inValidB, inReadyB, outValidB, outReadyB;
    logic [74:0] inCandB;
    logic [1:0]  inSelB;
    logic [23:0] outMantB;
    logic        outOvfB, outSelErrB, cntClrB;
    logic [3:0]  ovfCntB;

    logic [24:0] candA [4];
    logic [24:0] candB [3];

    word_t       qA[$];
    word_t       qB[$];
    logic [15:0] expCntA;
    logic [3:0]  expCntB;

    int checks = 0;
    int errors = 0;

    round_cand_sel_pipe #(.N(4), .MW(24), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidA), .in_ready(inReadyA),
        .in_cand(inCandA), .in_sel(inSelA),
        .out_valid(outValidA), .out_ready(outReadyA),
        .out_mant(outMantA), .out_ovf(outOvfA), .out_sel_err(outSelErrA),
        .cnt_clr(cntClrA), .ovf_cnt(ovfCntA)
    );

    round_cand_sel_pipe #(.N(3), .MW(24), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidB), .in_ready(inReadyB),
        .in_cand(inCandB), .in_sel(inSelB),
        .out_valid(outValidB), .out_ready(outReadyB),
        .out_mant(outMantB), .out_ovf(outOvfB), .out_sel_err(outSelErrB),
        .cnt_clr(cntClrB), .ovf_cnt(ovfCntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-candidate arrays onto the flat buses.
    always_comb begin
        inCandA = '0;
        inCandB = '0;
        for (int k = 0; k < 4; k++) inCandA[k*25 +: 25] = candA[k];
        for (int k = 0; k < 3; k++) inCandB[k*25 +: 25] = candB[k];
    end

    // Reference behaviour of one selection.
    function automatic word_t model(input logic [24:0] c, input logic err);
        word_t w;
        w.mant = c[23:0];
        w.ovf  = c[24];
        w.err  = err;
`ifdef RND_OVF_NORM_EN
        if (c[24]) w.mant = {1'b1, c[23:1]};
`endif
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit useB, input logic v, input logic [1:0] sel, input logic rdy);
        if (useB) begin
            inValidB = v; inSelB = sel; outReadyB = rdy;
        end else begin
            inValidA = v; inSelA = sel; outReadyA = rdy;
        end
    endtask

    // One clock: sample just before the rising edge, score both DUTs, then
    // step past the edge and check the counters.
    task automatic tick();
        word_t exp;
        @(negedge clk);
        #4;
        if (outValidA && outReadyA) begin
            if (qA.size() == 0) checkOutput("A_unexpected_word", qA.size(), 1);
            else begin
                exp = qA.pop_front();
                checkOutput("A_mant", outMantA, exp.mant);
                checkOutput("A_ovf", outOvfA, exp.ovf);
                checkOutput("A_sel_err", outSelErrA, exp.err);
                if (!cntClrA && exp.ovf && expCntA != 16'hFFFF) expCntA++;
            end
        end
        if (cntClrA) expCntA = '0;
        if (outValidB && outReadyB) begin
            if (qB.size() == 0) checkOutput("B_unexpected_word", qB.size(), 1);
            else begin
                exp = qB.pop_front();
                checkOutput("B_mant", outMantB, exp.mant);
                checkOutput("B_ovf", outOvfB, exp.ovf);
                checkOutput("B_sel_err", outSelErrB, exp.err);
                if (!cntClrB && exp.ovf && expCntB != 4'hF) expCntB++;
            end
        end
        if (cntClrB) expCntB = '0;
        if (inValidA && inReadyA) qA.push_back(model(candA[inSelA], 1'b0));
        if (inValidB && inReadyB) begin
            if (inSelB < 2'd3) qB.push_back(model(candB[inSelB], 1'b0));
            else               qB.push_back(model(candB[0], 1'b1));
        end
        @(posedge clk);
        #1;
        checkOutput("A_ovf_cnt", ovfCntA, expCntA);
        checkOutput("B_ovf_cnt", ovfCntB, expCntB);
    endtask

    initial begin
        rst_n = 1'b0;
        cntClrA = 1'b0; cntClrB = 1'b0;
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        applyStimulus(1, 1'b0, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) candA[k] = '0;
        for (int k = 0; k < 3; k++) candB[k] = '0;
        expCntA = '0; expCntB = '0;

        // Reset state.
        #1;
        checkOutput("rst_out_valid", outValidA, 0);
        checkOutput("rst_out_mant", outMantA, 0);
        checkOutput("rst_out_ovf", outOvfA, 0);
        checkOutput("rst_sel_err", outSelErrA, 0);
        checkOutput("rst_ovf_cnt", ovfCntA, 0);
        checkOutput("rst_in_ready", inReadyA, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Overflow flag follows the selected candidate, not its neighbour.
        $display("[TB] select candidate 3 with overflow");
        candA[3] = {1'b1, 24'h000000};
        candA[2] = {1'b0, 24'hFFFFFF};
        applyStimulus(0, 1'b1, 2'd3, 1'b1);
        tick();
        checkOutput("t1_out_valid", outValidA, 1);
`ifdef RND_OVF_NORM_EN
        checkOutput("t1_out_mant", outMantA, 32'h800000);
`else
        checkOutput("t1_out_mant", outMantA, 32'h000000);
`endif
        checkOutput("t1_out_ovf", outOvfA, 1);
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("t1_ovf_cnt_one", ovfCntA, 1);

        // Back-to-back stream, no bubbles.
        $display("[TB] back-to-back stream");
        for (int k = 0; k < 4; k++) candA[k] = {1'b0, 24'(k + 1)};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b1, 2'(k), 1'b1);
            checkOutput("stream_in_ready", inReadyA, 1);
            tick();
            checkOutput("stream_out_valid", outValidA, 1);
        end
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("stream_drained", outValidA, 0);

        // Stall: two words fit, the third is held off.
        $display("[TB] stall and release");
        candA[0] = {1'b1, 24'hA5A5A5};
        candA[1] = {1'b0, 24'h5A5A5A};
        candA[2] = {1'b1, 24'h00FF01};
        applyStimulus(0, 1'b1, 2'd0, 1'b0);
        checkOutput("stall_ready_c1", inReadyA, 1);
        tick();
        applyStimulus(0, 1'b1, 2'd1, 1'b0);
        checkOutput("stall_ready_c2", inReadyA, 1);
        tick();
        applyStimulus(0, 1'b1, 2'd2, 1'b0);
        checkOutput("stall_ready_c3", inReadyA, 0);
        tick();
        checkOutput("stall_hold_mant", outMantA, model(candA[0], 1'b0).mant);
        checkOutput("stall_queue_depth", qA.size(), 2);
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("release_ready", inReadyA, 1);
        tick();
        checkOutput("release_drained", outValidA, 0);

        // Out-of-range select on the N=3 instance, then a normal one.
        $display("[TB] out-of-range select");
        candB[0] = {1'b0, 24'h123456};
        candB[1] = {1'b0, 24'h0BEEF0};
        applyStimulus(1, 1'b1, 2'd3, 1'b1);
        tick();
        checkOutput("B_err_flag", outSelErrB, 1);
        checkOutput("B_err_mant", outMantB, 32'h123456);
        applyStimulus(1, 1'b1, 2'd1, 1'b1);
        tick();
        checkOutput("B_ok_flag", outSelErrB, 0);

        // Counter saturation at 4'hF, then clear colliding with an increment.
        $display("[TB] counter saturation and clear");
        for (int i = 0; i < 17; i++) begin
            candB[2] = {1'b1, 24'(i * 3 + 2)};
            applyStimulus(1, 1'b1, 2'd2, 1'b1);
            tick();
        end
        applyStimulus(1, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("B_cnt_saturated", ovfCntB, 32'hF);
        applyStimulus(1, 1'b1, 2'd2, 1'b1);
        tick();
        applyStimulus(1, 1'b0, 2'd0, 1'b1);
        cntClrB = 1'b1;
        checkOutput("B_clr_during_ovf_xfer", outOvfB & outValidB, 1);
        tick();
        cntClrB = 1'b0;
        checkOutput("B_cnt_cleared", ovfCntB, 0);

        // Reset while both entries are full.
        $display("[TB] reset with full buffer");
        candA[1] = {1'b1, 24'h777777};
        candA[2] = {1'b0, 24'h222222};
        applyStimulus(0, 1'b1, 2'd1, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 2'd2, 1'b0);
        tick();
        checkOutput("full_in_ready", inReadyA, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValidA, 0);
        checkOutput("midrst_in_ready", inReadyA, 1);
        checkOutput("midrst_ovf_cnt", ovfCntA, 0);
        qA.delete();
        qB.delete();
        expCntA = '0;
        expCntB = '0;
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_no_stale", outValidA, 0);
        end

        checkOutput("A_queue_empty", qA.size(), 0);
        checkOutput("B_queue_empty", qB.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
